// File: rtl/spi_slave_fsm.sv
// SPI slave front end: shifts MOSI into 10-bit command words, shifts 8-bit read data out on MISO,
// and exports the transaction phase as mode_sel for the downstream select mux.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | SS_n high, waiting for a frame
// CHK_CMD   | first bit of the word decides WRITE / READ_ADD / READ_DATA
// WRITE     | receiving a write word
// READ_ADD  | receiving a read-address word; marks an address as seen
// READ_DATA | receiving a read-data word, then waiting for and sending tx_data
module spi_slave_fsm #(
    parameter int RX_W = 10,
    parameter int TX_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            SS_n,
    input  logic            MOSI,
    input  logic [TX_W-1:0] tx_data,
    input  logic            tx_valid,
    output logic            MISO,
    output logic [RX_W-1:0] rx_data,
    output logic            rx_valid,
    output logic [1:0]      mode_sel
);

    localparam int CNT_W = $clog2(RX_W + 1);
    localparam int TXC_W = $clog2(TX_W + 1);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(RX_W - 1);
    localparam logic [CNT_W-1:0] C_FULL = CNT_W'(RX_W);

    typedef enum logic [2:0] {
        IDLE      = 3'b000,
        CHK_CMD   = 3'b001,
        WRITE     = 3'b010,
        READ_ADD  = 3'b011,
        READ_DATA = 3'b100
    } state_t;

    state_t            r_state;
    logic [1:0]        r_mode_sel;
    logic [CNT_W-1:0]  r_cnt;
    logic [RX_W-2:0]   r_shift;
    logic [RX_W-1:0]   r_rx_data;
    logic              r_rx_valid;
    logic              r_addr_seen;
    logic              r_tx_wait;
    logic              r_tx_busy;
    logic [TX_W-1:0]   r_tx_shift;
    logic [TXC_W-1:0]  r_tx_cnt;
    logic              r_miso;
    logic [RX_W-1:0]   w_word;

    assign w_word = {r_shift, MOSI};

    function automatic logic [1:0] mode_of(input state_t s);
        case (s)
            WRITE:     mode_of = 2'b01;
            READ_ADD:  mode_of = 2'b10;
            READ_DATA: mode_of = 2'b11;
            default:   mode_of = 2'b00;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_mode_sel  <= 2'b00;
            r_cnt       <= '0;
            r_shift     <= '0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_addr_seen <= 1'b0;
            r_tx_wait   <= 1'b0;
            r_tx_busy   <= 1'b0;
            r_tx_shift  <= '0;
            r_tx_cnt    <= '0;
            r_miso      <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            // Deselect aborts any frame; a partial word is dropped, addr_seen survives.
            if (r_state != IDLE && SS_n) begin
                r_state    <= IDLE;
                r_mode_sel <= mode_of(IDLE);
                r_cnt      <= '0;
                r_shift    <= '0;
                r_tx_wait  <= 1'b0;
                r_tx_busy  <= 1'b0;
                r_miso     <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_cnt  <= '0;
                        r_miso <= 1'b0;
                        if (!SS_n) begin
                            r_state    <= CHK_CMD;
                            r_mode_sel <= mode_of(CHK_CMD);
                        end
                    end
                    CHK_CMD: begin
                        r_shift   <= {{(RX_W-2){1'b0}}, MOSI};
                        r_cnt     <= CNT_W'(1);
                        r_tx_wait <= 1'b0;
                        r_tx_busy <= 1'b0;
                        r_miso    <= 1'b0;
                        if (!MOSI) begin
                            r_state    <= WRITE;
                            r_mode_sel <= mode_of(WRITE);
                        end else if (!r_addr_seen) begin
                            r_state    <= READ_ADD;
                            r_mode_sel <= mode_of(READ_ADD);
                        end else begin
                            r_state    <= READ_DATA;
                            r_mode_sel <= mode_of(READ_DATA);
                        end
                    end
                    WRITE, READ_ADD, READ_DATA: begin
                        if (r_cnt < C_FULL) begin
                            r_shift <= w_word[RX_W-2:0];
                            r_cnt   <= r_cnt + CNT_W'(1);
                            if (r_cnt == C_LAST) begin
                                r_rx_data  <= w_word;
                                r_rx_valid <= 1'b1;
                                if (r_state == READ_ADD)
                                    r_addr_seen <= 1'b1;
                                if (r_state == READ_DATA) begin
                                    r_addr_seen <= 1'b0;
                                    r_tx_wait   <= 1'b1;
                                end
                            end
                        end
                        // Read data leaves MSB first; tx_valid is honoured once per READ_DATA entry.
                        if (r_state == READ_DATA && r_tx_wait && tx_valid) begin
                            r_tx_wait  <= 1'b0;
                            r_tx_busy  <= 1'b1;
                            r_miso     <= tx_data[TX_W-1];
                            r_tx_shift <= tx_data << 1;
                            r_tx_cnt   <= TXC_W'(TX_W - 1);
                        end else if (r_state == READ_DATA && r_tx_busy) begin
                            if (r_tx_cnt != '0) begin
                                r_miso     <= r_tx_shift[TX_W-1];
                                r_tx_shift <= r_tx_shift << 1;
                                r_tx_cnt   <= r_tx_cnt - TXC_W'(1);
                            end else begin
                                r_miso    <= 1'b0;
                                r_tx_busy <= 1'b0;
                            end
                        end else begin
                            r_miso <= 1'b0;
                        end
                    end
                    default: begin
                        r_state    <= IDLE;
                        r_mode_sel <= mode_of(IDLE);
                        r_cnt      <= '0;
                        r_miso     <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign MISO     = r_miso;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign mode_sel = r_mode_sel;

endmodule

// File: tb/tb_spi_slave_fsm.sv
// Bench for spi_slave_fsm: directed frames, received words checked through a scoreboard queue
// drained by a monitor on rx_valid; MISO and mode_sel checked against hand-computed values.
module tb_spi_slave_fsm;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       SS_n;
    logic       MOSI;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       MISO;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [1:0] mode_sel;

    int n_tests = 0;
    int n_fail  = 0;
    logic [9:0] exp_q[$];
    logic       prev_rx_valid = 1'b0;

    spi_slave_fsm #(.RX_W(10), .TX_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .MISO     (MISO),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .mode_sel (mode_sel)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every rx_valid strobe must match the oldest expected word and last one cycle.
    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_rx_valid", 32'd1, 32'd0);
            end else begin
                check("sb_rx_data", {22'd0, rx_data}, {22'd0, exp_q.pop_front()});
            end
            check("sb_rx_valid_width", {31'd0, prev_rx_valid}, 32'd0);
        end
        prev_rx_valid = (rx_valid === 1'b1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame();
        SS_n = 1'b0;
        MOSI = 1'b0;
        tick();
        check("chk_cmd_mode", {30'd0, mode_sel}, 32'd0);
    endtask

    task automatic end_frame();
        SS_n = 1'b1;
        tick();
        check("idle_mode", {30'd0, mode_sel}, 32'd0);
        check("idle_miso", {31'd0, MISO}, 32'd0);
    endtask

    task automatic send_bits(input logic [9:0] w, input int n, input logic [1:0] exp_mode);
        for (int i = 9; i > 9 - n; i--) begin
            MOSI = w[i];
            tick();
            if (i == 9) check("cmd_mode", {30'd0, mode_sel}, {30'd0, exp_mode});
            check("rx_miso_low", {31'd0, MISO}, 32'd0);
        end
    endtask

    task automatic send_word(input logic [9:0] w, input logic [1:0] exp_mode);
        exp_q.push_back(w);
        send_bits(w, 10, exp_mode);
        check("rx_valid_high", {31'd0, rx_valid}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] exp_byte;
        rst_n = 1'b0; SS_n = 1'b1; MOSI = 1'b0; tx_data = 8'h00; tx_valid = 1'b0;
        tick(); tick();
        check("rst_miso", {31'd0, MISO}, 32'd0);
        check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_rx_data", {22'd0, rx_data}, 32'd0);
        check("rst_mode", {30'd0, mode_sel}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Write 0x0AA
        start_frame();
        send_word(10'h0AA, 2'b01);
        tick();
        check("rx_valid_low", {31'd0, rx_valid}, 32'd0);
        check("write_mode_hold", {30'd0, mode_sel}, 32'd1);
        end_frame();

        // Read address 0x207 sets addr_seen
        start_frame();
        send_word(10'h207, 2'b10);
        tick();
        check("rx_valid_low2", {31'd0, rx_valid}, 32'd0);
        end_frame();

        // Read data: addr_seen steers to READ_DATA, then 0xC5 out on MISO
        start_frame();
        send_word(10'h35A, 2'b11);
        check("wait_miso_low", {31'd0, MISO}, 32'd0);
        tick();
        check("wait_miso_low2", {31'd0, MISO}, 32'd0);
        tx_data = 8'hC5; tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0; tx_data = 8'h00;
        exp_byte = 8'b1100_0101;
        for (int k = 7; k >= 0; k--) begin
            check("miso_c5_bit", {31'd0, MISO}, {31'd0, exp_byte[k]});
            tick();
        end
        check("miso_after_byte", {31'd0, MISO}, 32'd0);
        tx_data = 8'hFF; tx_valid = 1'b1;
        tick();
        check("miso_second_tx_valid_ignored", {31'd0, MISO}, 32'd0);
        tick();
        check("miso_second_tx_valid_ignored2", {31'd0, MISO}, 32'd0);
        tx_valid = 1'b0;
        end_frame();

        // addr_seen cleared by READ_DATA: read command goes to READ_ADD again
        start_frame();
        send_word(10'h2F0, 2'b10);
        end_frame();

        // Reset clears addr_seen
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        start_frame();
        send_word(10'h2AB, 2'b10);
        end_frame();

        // Mid-transmit reset after 3 MISO bits of 0xA5
        start_frame();
        send_word(10'h3C3, 2'b11);
        tx_data = 8'hA5; tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        exp_byte = 8'hA5;
        for (int k = 7; k >= 5; k--) begin
            check("miso_a5_bit", {31'd0, MISO}, {31'd0, exp_byte[k]});
            if (k > 5) tick();
        end
        rst_n = 1'b0;
        tick();
        check("rst_mid_miso", {31'd0, MISO}, 32'd0);
        check("rst_mid_mode", {30'd0, mode_sel}, 32'd0);
        check("rst_mid_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_mid_rx_data", {22'd0, rx_data}, 32'd0);
        rst_n = 1'b1; SS_n = 1'b1;
        tick();
        check("post_rst_miso", {31'd0, MISO}, 32'd0);
        start_frame();
        send_word(10'h211, 2'b10);
        end_frame();

        // Abort after 5 bits of a write, then a clean write
        start_frame();
        send_bits(10'h0B6, 5, 2'b01);
        end_frame();
        check("abort_rx_valid", {31'd0, rx_valid}, 32'd0);
        start_frame();
        send_word(10'h0F3, 2'b01);
        end_frame();

        // SS_n rises on the 10th-bit edge: no word
        start_frame();
        send_bits(10'h155, 9, 2'b01);
        MOSI = 1'b1; SS_n = 1'b1;
        tick();
        check("ss_wins_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("ss_wins_mode", {30'd0, mode_sel}, 32'd0);
        tick();
        check("ss_wins_rx_valid2", {31'd0, rx_valid}, 32'd0);

        // tx_valid in IDLE and during WRITE has no effect
        tx_data = 8'hFF; tx_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("idle_tx_valid_miso", {31'd0, MISO}, 32'd0);
            check("idle_tx_valid_mode", {30'd0, mode_sel}, 32'd0);
        end
        start_frame();
        send_word(10'h0C5, 2'b01);
        tick();
        check("write_tx_valid_miso", {31'd0, MISO}, 32'd0);
        check("write_tx_valid_mode", {30'd0, mode_sel}, 32'd1);
        tx_valid = 1'b0;
        end_frame();

        tick(); tick();
        check("sb_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
